wb_stage_reg: RTL and testbench
===============================

Name: wb_stage_reg

Overview:
Parametrised writeback stage: MEM/WB pipeline register plus writeback logic. Registers MEM-stage results under stall/flush control and performs load-data extraction (byte/half/word, signed/unsigned) from the aligned memory word. Gates register-file and HI/LO commits on exception status, and keeps a retired-instruction counter. Sits between the data-cache MEM stage and the register file / HI-LO / CP0 commit ports.

Parameters:
WIDTH, 32, datapath width; must be 32 or 64.
RADDR_W, 7, register-file write-address width.
EXC_W, 4, exception-code width.
CNT_W, 32, retired-instruction counter width.
EXC_COMMIT_CODE, 6, exception code whose register write still commits when the EPC is word-aligned.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_i  in  1  hold the WB register contents
flush_i  in  1  insert a bubble
valid_i  in  1  MEM stage holds a valid instruction
pc_i  in  32  instruction PC
epc_i  in  32  EPC associated with the instruction
alu_i  in  WIDTH  ALU result; the low bits are the load byte address
mem_rdata_i  in  WIDTH  aligned memory read word
mem_to_reg_i  in  1  select load data over alu_i
mem_rtype_i  in  3  load type
reg_we_i  in  1  register-file write request
waddr_i  in  RADDR_W  destination register
hilo_we_i  in  1  HI/LO write request
hilo_i  in  2*WIDTH  HI/LO data
exc_i  in  EXC_W  exception code; 0 means none
is_ds_i  in  1  instruction is in a delay slot
rf_we_o  out  1  register-file write enable
rf_waddr_o  out  RADDR_W  register-file write address
rf_wdata_o  out  WIDTH  register-file write data
hilo_we_o  out  1  HI/LO write enable
hilo_o  out  2*WIDTH  HI/LO write data
pc_o  out  32  committed PC
exc_o  out  EXC_W  exception code
is_ds_o  out  1  delay-slot flag
valid_o  out  1  WB register holds a valid instruction
retired_o  out  CNT_W  retired-instruction count

Behaviour:
- Register update, per rising edge of clk, in priority order rst > flush_i > stall_i > load:
  - rst: all stored fields cleared; valid, exception code, counter and enables go to 0.
  - flush_i: valid cleared, exception code cleared; other stored fields don't care.
  - stall_i: all stored fields hold.
  - Otherwise: all *_i captured.
- Input-to-output latency: 1 cycle. Every output is combinational from the registered fields.
- Load extraction uses registered alu[1:0]; for WIDTH=64, alu[2] first selects the 32-bit word.
  - rtype 0: LW, full word.
  - rtype 1: LB, sign-extended byte at offset.
  - rtype 2: LBU, zero-extended byte at offset.
  - rtype 3: LH, sign-extended half at alu[1]; alu[0] is ignored.
  - rtype 4: LHU, zero-extended half at alu[1].
  - rtype 5-7: treated as LW.
  - For WIDTH=64, the 32-bit result is sign-extended for LW.
- rf_wdata_o = mem_to_reg ? extracted load data : alu.
- Commit condition: commit = valid & (exc==0 | (exc==EXC_COMMIT_CODE & epc[1:0]==0)).
  - rf_we_o = commit & reg_we & (waddr != 0). A write to register 0 is suppressed.
  - hilo_we_o = commit & hilo_we.
- rf_waddr_o, hilo_o, pc_o and is_ds_o are passthrough from the register.
- exc_o = valid ? exc : 0.
- valid_o = valid.
- retired_o increments by 1 on each edge where the register holds a committing instruction being replaced.
  - The increment is evaluated on current contents when not stalled (rst has priority), so a stalled instruction is counted exactly once.
  - The counter wraps modulo 2^CNT_W.
- Simultaneous flush_i and stall_i: flush wins.
- Reset asserted mid-stall: all fields and the counter clear on that edge.

Test Plan:
1. Reset, then load reg_we_i=1, waddr_i=5, alu_i=0x1234, mem_to_reg_i=0 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x00001234, valid_o=1.
2. mem_rdata_i=0x80FF7F01, mem_to_reg_i=1:
   - alu[1:0]=3, rtype 1 -> rf_wdata_o=0xFFFFFF80.
   - alu[1:0]=3, rtype 2 -> 0x00000080.
   - alu[1:0]=2, rtype 3 -> 0xFFFF80FF.
   - alu[1:0]=2, rtype 4 -> 0x000080FF.
   - rtype 0 -> 0x80FF7F01.
3. exc_i=3 with reg_we_i=1 -> rf_we_o=0, exc_o=3. exc_i=6 with epc_i=0x100 -> rf_we_o=1. exc_i=6 with epc_i=0x102 -> rf_we_o=0.
4. Capture an instruction, then assert stall_i for 3 cycles while inputs change -> outputs hold the original values and retired_o increments by exactly 1 after the stall ends.
5. flush_i and stall_i asserted together -> next cycle valid_o=0, rf_we_o=0, hilo_we_o=0, exc_o=0.
6. waddr_i=0 with reg_we_i=1 -> rf_we_o=0. Force the counter to 0xFFFFFFFF (CNT_W=32) and retire one instruction -> retired_o=0.

Source files
------------

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register with load extraction, commit gating
// and a retired-instruction counter.
module wb_stage_reg #(
  parameter int WIDTH           = 32,
  parameter int RADDR_W         = 7,
  parameter int EXC_W           = 4,
  parameter int CNT_W           = 32,
  parameter int EXC_COMMIT_CODE = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic [31:0]          pc_i,
  input  logic [31:0]          epc_i,
  input  logic [WIDTH-1:0]     alu_i,
  input  logic [WIDTH-1:0]     mem_rdata_i,
  input  logic                 mem_to_reg_i,
  input  logic [2:0]           mem_rtype_i,
  input  logic                 reg_we_i,
  input  logic [RADDR_W-1:0]   waddr_i,
  input  logic                 hilo_we_i,
  input  logic [2*WIDTH-1:0]   hilo_i,
  input  logic [EXC_W-1:0]     exc_i,
  input  logic                 is_ds_i,
  output logic                 rf_we_o,
  output logic [RADDR_W-1:0]   rf_waddr_o,
  output logic [WIDTH-1:0]     rf_wdata_o,
  output logic                 hilo_we_o,
  output logic [2*WIDTH-1:0]   hilo_o,
  output logic [31:0]          pc_o,
  output logic [EXC_W-1:0]     exc_o,
  output logic                 is_ds_o,
  output logic                 valid_o,
  output logic [CNT_W-1:0]     retired_o
);

  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic [31:0]          epc;
    logic [WIDTH-1:0]     alu;
    logic [WIDTH-1:0]     rdata;
    logic                 m2r;
    logic [2:0]           rtype;
    logic                 we;
    logic [RADDR_W-1:0]   waddr;
    logic                 hwe;
    logic [2*WIDTH-1:0]   hilo;
    logic [EXC_W-1:0]     exc;
    logic                 ds;
  } wb_t;

  wb_t              wb_d, wb_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             exc_ok;
  logic             commit;
  logic [31:0]      word;
  logic [7:0]       byt;
  logic [15:0]      half;
  logic [WIDTH-1:0] ld;

  assign exc_ok = (wb_q.exc == '0) ||
                  ((wb_q.exc == EXC_W'(EXC_COMMIT_CODE)) &&
                   (wb_q.epc[1:0] == 2'b00));
  assign commit = wb_q.valid && exc_ok;

  always_comb begin
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wb_d.valid = 1'b0;
      wb_d.exc   = '0;
    end else if (!stall_i) begin
      wb_d = '{valid: valid_i,     pc: pc_i,
               epc: epc_i,         alu: alu_i,
               rdata: mem_rdata_i, m2r: mem_to_reg_i,
               rtype: mem_rtype_i, we: reg_we_i,
               waddr: waddr_i,     hwe: hilo_we_i,
               hilo: hilo_i,       exc: exc_i,
               ds: is_ds_i};
    end
    // The held instruction retires on the edge that replaces it
    if (commit && (flush_i || !stall_i))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  if (WIDTH == 64) begin : g_w64
    assign word = wb_q.alu[2] ? wb_q.rdata[63:32]
                              : wb_q.rdata[31:0];
  end else begin : g_w32
    assign word = wb_q.rdata[31:0];
  end

  always_comb begin
    byt = word[7:0];
    unique case (wb_q.alu[1:0])
      2'd1:    byt = word[15:8];
      2'd2:    byt = word[23:16];
      2'd3:    byt = word[31:24];
      default: byt = word[7:0];
    endcase
  end

  assign half = wb_q.alu[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld = WIDTH'(signed'(word));
    case (wb_q.rtype)
      3'd1:    ld = WIDTH'(signed'(byt));
      3'd2:    ld = WIDTH'(byt);
      3'd3:    ld = WIDTH'(signed'(half));
      3'd4:    ld = WIDTH'(half);
      default: ld = WIDTH'(signed'(word));
    endcase
  end

  assign rf_wdata_o = wb_q.m2r ? ld : wb_q.alu;
  assign rf_we_o    = commit && wb_q.we &&
                      (wb_q.waddr != '0);
  assign hilo_we_o  = commit && wb_q.hwe;
  assign rf_waddr_o = wb_q.waddr;
  assign hilo_o     = wb_q.hilo;
  assign pc_o       = wb_q.pc;
  assign is_ds_o    = wb_q.ds;
  assign exc_o      = wb_q.valid ? wb_q.exc : '0;
  assign valid_o    = wb_q.valid;
  assign retired_o  = cnt_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Scoreboard bench for wb_stage_reg; a second instance with a
// 3-bit counter exercises counter wrap.
module tb_wb_stage_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, vld;
  logic [31:0] pc, epc, alu, rdata;
  logic        m2r, we, hwe, ds;
  logic [2:0]  rt;
  logic [6:0]  wa;
  logic [63:0] hilo;
  logic [3:0]  exc;

  logic        rf_we, hilo_we, is_ds, valid;
  logic [6:0]  rf_wa;
  logic [31:0] rf_wd, pc_out, ret;
  logic [63:0] hilo_out;
  logic [3:0]  exc_out;

  logic        w_rf_we, w_hilo_we, w_ds, w_valid;
  logic [6:0]  w_wa;
  logic [31:0] w_wd, w_pc;
  logic [63:0] w_hilo;
  logic [3:0]  w_exc;
  logic [2:0]  w_ret;

  always #5 clk = ~clk;

  wb_stage_reg dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .valid_i(vld), .pc_i(pc), .epc_i(epc), .alu_i(alu),
    .mem_rdata_i(rdata), .mem_to_reg_i(m2r),
    .mem_rtype_i(rt), .reg_we_i(we), .waddr_i(wa),
    .hilo_we_i(hwe), .hilo_i(hilo), .exc_i(exc),
    .is_ds_i(ds), .rf_we_o(rf_we), .rf_waddr_o(rf_wa),
    .rf_wdata_o(rf_wd), .hilo_we_o(hilo_we),
    .hilo_o(hilo_out), .pc_o(pc_out), .exc_o(exc_out),
    .is_ds_o(is_ds), .valid_o(valid), .retired_o(ret)
  );

  wb_stage_reg #(.CNT_W(3)) u_wrap (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
    .valid_i(vld), .pc_i(pc), .epc_i(epc), .alu_i(alu),
    .mem_rdata_i(rdata), .mem_to_reg_i(m2r),
    .mem_rtype_i(rt), .reg_we_i(we), .waddr_i(wa),
    .hilo_we_i(hwe), .hilo_i(hilo), .exc_i(exc),
    .is_ds_i(ds), .rf_we_o(w_rf_we), .rf_waddr_o(w_wa),
    .rf_wdata_o(w_wd), .hilo_we_o(w_hilo_we),
    .hilo_o(w_hilo), .pc_o(w_pc), .exc_o(w_exc),
    .is_ds_o(w_ds), .valid_o(w_valid), .retired_o(w_ret)
  );

  typedef struct packed {
    logic        v;
    logic        commit;
    logic        we;
    logic [6:0]  wa;
    logic [31:0] wd;
    logic        hwe;
    logic [63:0] hilo;
    logic [31:0] pc;
    logic [3:0]  exc;
    logic        ds;
    logic [31:0] cnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   n_tot = 0;
  int   n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] expv);
    n_tot++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, expv, $time);
    end
  endtask

  function automatic logic [31:0] ld_ref(
      input logic [31:0] d, input logic [1:0] a,
      input logic [2:0] t);
    logic [31:0] sb_, sh_;
    logic [7:0]  b;
    logic [15:0] h;
    sb_ = d >> (a * 8);
    sh_ = d >> (a[1] * 16);
    b = sb_[7:0];
    h = sh_[15:0];
    case (t)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'h0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'h0, h};
      default: return d;
    endcase
  endfunction

  task automatic cyc();
    exp_t e;
    logic ok;
    if (rst) begin
      m = '0;
    end else begin
      if ((flush || !stall) && m.commit)
        m.cnt = m.cnt + 1;
      if (flush) begin
        m.v = 0; m.commit = 0; m.we = 0;
        m.hwe = 0; m.exc = 0;
      end else if (!stall) begin
        ok = (exc == 0) || (exc == 6 && epc[1:0] == 0);
        m.v      = vld;
        m.commit = vld && ok;
        m.we     = m.commit && we && (wa != 0);
        m.hwe    = m.commit && hwe;
        m.exc    = vld ? exc : 4'd0;
        m.wa     = wa;
        m.hilo   = hilo;
        m.pc     = pc;
        m.ds     = ds;
        m.wd     = m2r ? ld_ref(rdata, alu[1:0], rt) : alu;
      end
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("valid", 64'(valid), 64'(e.v));
    chk("rf_we", 64'(rf_we), 64'(e.we));
    chk("hilo_we", 64'(hilo_we), 64'(e.hwe));
    chk("exc", 64'(exc_out), 64'(e.exc));
    chk("retired", 64'(ret), 64'(e.cnt));
    chk("retired_w3", 64'(w_ret), 64'(e.cnt[2:0]));
    if (e.v) begin
      chk("waddr", 64'(rf_wa), 64'(e.wa));
      chk("wdata", 64'(rf_wd), 64'(e.wd));
      chk("hilo", hilo_out, e.hilo);
      chk("pc", 64'(pc_out), 64'(e.pc));
      chk("is_ds", 64'(is_ds), 64'(e.ds));
    end
    pc = pc + 4;
  endtask

  task automatic ld_t(input logic [1:0] a,
                      input logic [2:0] t);
    alu = {30'h0, a};
    rt  = t;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    m = '0;
    rst = 1; stall = 0; flush = 0; vld = 0;
    pc = 32'h1000; epc = 0; alu = 0; rdata = 0;
    m2r = 0; rt = 0; we = 0; wa = 0; hwe = 0;
    hilo = 0; exc = 0; ds = 0;
    #2;
    cyc();
    cyc();
    rst = 0;

    vld = 1; we = 1; wa = 5; alu = 32'h1234;
    cyc();
    chk("t1_wdata", 64'(rf_wd), 64'h1234);

    rdata = 32'h80FF7F01; m2r = 1;
    ld_t(2'd3, 3'd1);
    chk("t2_lb", 64'(rf_wd), 64'hFFFFFF80);
    ld_t(2'd3, 3'd2);
    ld_t(2'd2, 3'd3);
    chk("t2_lh", 64'(rf_wd), 64'hFFFF80FF);
    ld_t(2'd2, 3'd4);
    ld_t(2'd0, 3'd0);
    ld_t(2'd1, 3'd1);
    ld_t(2'd1, 3'd2);
    ld_t(2'd0, 3'd3);
    ld_t(2'd3, 3'd4);
    ld_t(2'd2, 3'd6);
    m2r = 0;

    exc = 3; cyc();
    chk("t3_exc3", 64'(exc_out), 64'd3);
    exc = 6; epc = 32'h100; cyc();
    exc = 6; epc = 32'h102; cyc();
    exc = 0; epc = 0;

    hwe = 1; hilo = 64'hDEADBEEF_01234567; cyc();
    hwe = 0;

    ds = 1; alu = 32'hCAFE; wa = 9; cyc();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      alu = $urandom; wa = 7'($urandom); ds = 0;
      cyc();
    end
    stall = 0; cyc();

    flush = 1; stall = 1; hwe = 1; cyc();
    flush = 0; stall = 0; hwe = 0;

    wa = 0; we = 1; cyc();

    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      vld   = ($urandom_range(0, 5) != 0);
      alu   = $urandom; rdata = $urandom;
      m2r   = 1'($urandom); rt = 3'($urandom);
      we    = 1'($urandom); wa = 7'($urandom);
      hwe   = 1'($urandom);
      hilo  = {$urandom, $urandom};
      exc   = ($urandom_range(0, 3) == 0) ?
              4'($urandom) : 4'd0;
      epc   = $urandom; ds = 1'($urandom);
      cyc();
    end

    stall = 1; flush = 0; vld = 1; exc = 0; cyc();
    rst = 1; cyc();
    rst = 0; stall = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
